pio_instr_mem: RTL and testbench

Instruction memory for one PIO state machine. Host-side loader writes a program through a valid/ready stream; the program counter reads it back each cycle. This block is the read target of `program_counter`: `program_counter` drives `pc` and `pc_en`, and this block returns the instruction word. While a load is in progress, `exec_hold` stalls execution.

---
 rtl/pio_pkg.sv | 24 ++
 rtl/pio_instr_ram.sv | 59 +++++
 rtl/pio_instr_mem.sv | 126 ++++++++++++
 tb/tb_pio_instr_mem.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_pkg
// Description : Shared constants and types for the PIO state-machine slice.
//               Widths here are also used by program_counter, so the fetch
//               address width always matches the instruction memory depth.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

  localparam int PIO_ADDR_W  = 4;
  localparam int PIO_INSTR_W = 16;
  localparam int PIO_DEPTH   = 1 << PIO_ADDR_W;

  // Program loader states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } pio_load_state_t;

endpackage : pio_pkg
`default_nettype wire

// File: rtl/pio_instr_ram.sv
`default_nettype none
// ============================================================================
// Module      : pio_instr_ram
// Description : 2^ADDR_W x INSTR_W instruction storage. One synchronous
//               write port, one registered read port with read enable,
//               asynchronous clear of every word and of the read register.
// Ports       : clk, rst        - clock, async active-high clear
//               we/waddr/wdata  - write port
//               re/raddr        - read request and address
//               rdata/rvalid    - registered read data and its strobe
// Revision    : 1.0 - initial release
// ============================================================================
module pio_instr_ram
  import pio_pkg::*;
#(
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int INSTR_W = PIO_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata,
  output logic               rvalid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Reset clears the whole array so a partially loaded program never survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // rdata holds its last value when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= r_mem[raddr];
      end
    end
  end

endmodule : pio_instr_ram
`default_nettype wire

// File: rtl/pio_instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : pio_instr_mem
// Description : Instruction memory for one PIO state machine. A host loader
//               streams a program in over valid/ready; program_counter
//               fetches one word per cycle. Execution is held while loading.
// Ports       : clk, rst                       - clock, async active-high reset
//               load_start/origin/count        - load command (IDLE only)
//               wr_data/wr_valid/wr_ready      - program word stream
//               load_busy/load_done/exec_hold  - loader status
//               pc/rd_en                       - fetch request
//               instr/instr_valid              - registered fetch result
// Revision    : 1.0 - initial release
// ============================================================================
module pio_instr_mem
  import pio_pkg::*;
#(
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int INSTR_W = PIO_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_origin,
  input  logic [ADDR_W:0]    load_count,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic               exec_hold,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               rd_en,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid
);

  localparam int                c_depth     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   c_max_count = (ADDR_W + 1)'(c_depth);

  pio_load_state_t     r_state;
  pio_load_state_t     w_state_next;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_remaining;
  logic [ADDR_W:0]     w_count_clamped;
  logic                w_start_ok;
  logic                w_beat;
  logic                w_fetch;

  assign w_count_clamped = (load_count > c_max_count) ? c_max_count : load_count;
  assign w_start_ok      = load_start && (w_count_clamped != '0);
  // wr_ready is a pure state decode, so a beat never loops back through it.
  assign w_beat          = wr_valid && wr_ready;
  assign w_fetch         = rd_en && !exec_hold;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_start_ok) w_state_next = LOAD;
      LOAD: if (w_beat && (r_remaining == (ADDR_W + 1)'(1))) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    wr_ready  = 1'b0;
    load_busy = 1'b0;
    load_done = 1'b0;
    case (r_state)
      LOAD: begin
        wr_ready  = 1'b1;
        load_busy = 1'b1;
      end
      DONE: begin
        load_busy = 1'b1;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign exec_hold = load_busy;

  // Write pointer wraps naturally at the address width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_remaining <= '0;
    end else if ((r_state == IDLE) && w_start_ok) begin
      r_wr_ptr    <= load_origin;
      r_remaining <= w_count_clamped;
    end else if (w_beat) begin
      r_wr_ptr    <= r_wr_ptr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  pio_instr_ram #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (w_beat),
    .waddr  (r_wr_ptr),
    .wdata  (wr_data),
    .re     (w_fetch),
    .raddr  (pc),
    .rdata  (instr),
    .rvalid (instr_valid)
  );

endmodule : pio_instr_mem
`default_nettype wire

// File: tb/tb_pio_instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_instr_mem
// Description : Directed self-checking bench for pio_instr_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_instr_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [3:0]  load_origin = '0;
  logic [4:0]  load_count = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        load_busy;
  logic        load_done;
  logic        exec_hold;
  logic [3:0]  pc = '0;
  logic        rd_en = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  pio_instr_mem dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_origin (load_origin),
    .load_count  (load_count),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .exec_hold   (exec_hold),
    .pc          (pc),
    .rd_en       (rd_en),
    .instr       (instr),
    .instr_valid (instr_valid)
  );

  // Status cycle counters sampled mid-cycle
  always @(negedge clk) begin
    if (load_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (load_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] origin, input logic [4:0] count);
    load_origin = origin;
    load_count  = count;
    load_start  = 1'b1;
    tick();
    load_start  = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [3:0] a, input logic [15:0] exp);
    pc    = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk(tag, 32'(instr), 32'(exp));
  endtask

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_wr_ready",    32'(wr_ready),    32'd0);
    chk("rst_load_busy",   32'(load_busy),   32'd0);
    chk("rst_load_done",   32'(load_done),   32'd0);
    chk("rst_exec_hold",   32'(exec_hold),   32'd0);
    chk("rst_instr",       32'(instr),       32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- basic load: origin 0, count 3 ----------------
    busy_cnt = 0;
    done_cnt = 0;
    start(4'd0, 5'd3);
    chk("ld_wr_ready", 32'(wr_ready), 32'd1);
    chk("ld_busy",     32'(load_busy), 32'd1);
    beat(16'hA001);
    beat(16'hA002);
    beat(16'hA003);
    chk("ld_done",        32'(load_done), 32'd1);
    chk("ld_done_wr_rdy", 32'(wr_ready),  32'd0);
    tick();
    chk("ld_idle_hold", 32'(exec_hold), 32'd0);
    tick();
    chk("ld_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("ld_done_pulses", 32'(done_cnt), 32'd1);
    fetch("f0", 4'd0, 16'hA001);
    fetch("f1", 4'd1, 16'hA002);
    fetch("f2", 4'd2, 16'hA003);
    fetch("f3", 4'd3, 16'h0000);
    tick();
    chk("idle_valid_low", 32'(instr_valid), 32'd0);
    chk("idle_instr_hold", 32'(instr), 32'h0000);

    // ---------------- wrap load: origin 14, count 4 ----------------
    start(4'd14, 5'd4);
    beat(16'h1111);
    beat(16'h2222);
    beat(16'h3333);
    beat(16'h4444);
    chk("wrap_done", 32'(load_done), 32'd1);
    tick();
    fetch("wrap14", 4'd14, 16'h1111);
    fetch("wrap15", 4'd15, 16'h2222);
    fetch("wrap0",  4'd0,  16'h3333);
    fetch("wrap1",  4'd1,  16'h4444);
    fetch("wrap2",  4'd2,  16'hA003);

    // ---------------- stalled stream: origin 4, count 2 ----------------
    start(4'd4, 5'd2);
    beat(16'h5555);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_wr_ready", 32'(wr_ready),  32'd1);
      chk("stall_no_done",  32'(load_done), 32'd0);
    end
    beat(16'h6666);
    chk("stall_done", 32'(load_done), 32'd1);
    tick();
    fetch("stall4", 4'd4, 16'h5555);
    fetch("stall5", 4'd5, 16'h6666);
    fetch("stall6", 4'd6, 16'h0000);

    // ---------------- count 0 ignored ----------------
    start(4'd3, 5'd0);
    chk("cnt0_busy",  32'(load_busy), 32'd0);
    chk("cnt0_ready", 32'(wr_ready),  32'd0);
    chk("cnt0_done",  32'(load_done), 32'd0);

    // ---------------- count 20 clamps to 16 ----------------
    start(4'd0, 5'd20);
    for (int i = 0; i < 16; i++) begin
      chk("c20_ready", 32'(wr_ready), 32'd1);
      beat(16'hB000 + 16'(i));
    end
    chk("c20_done",  32'(load_done), 32'd1);
    chk("c20_ready_lo", 32'(wr_ready), 32'd0);
    wr_data  = 16'hFFFF;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("c20_idle", 32'(load_busy), 32'd0);
    fetch("c20_a0",  4'd0,  16'hB000);
    fetch("c20_a15", 4'd15, 16'hB00F);

    // ---------------- fetch refused during load, restart ignored ----------------
    fetch("pre_load", 4'd5, 16'hB005);
    start(4'd8, 5'd2);
    pc    = 4'd0;
    rd_en = 1'b1;
    load_origin = 4'd12;
    load_count  = 5'd1;
    load_start  = 1'b1;
    tick();
    load_start = 1'b0;
    rd_en      = 1'b0;
    chk("hold_valid", 32'(instr_valid), 32'd0);
    chk("hold_instr", 32'(instr),       32'hB005);
    chk("hold_busy",  32'(load_busy),   32'd1);
    beat(16'h7777);
    chk("restart_no_done", 32'(load_done), 32'd0);
    beat(16'h8888);
    chk("restart_done", 32'(load_done), 32'd1);
    tick();
    fetch("rs8",  4'd8,  16'h7777);
    fetch("rs9",  4'd9,  16'h8888);
    fetch("rs12", 4'd12, 16'hB00C);

    // ---------------- reset mid-load ----------------
    start(4'd10, 5'd4);
    beat(16'hAAAA);
    beat(16'hBBBB);
    rst = 1'b1;
    tick();
    chk("mrst_ready", 32'(wr_ready),    32'd0);
    chk("mrst_busy",  32'(load_busy),   32'd0);
    chk("mrst_done",  32'(load_done),   32'd0);
    chk("mrst_hold",  32'(exec_hold),   32'd0);
    chk("mrst_instr", 32'(instr),       32'd0);
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    tick();
    fetch("mrst10", 4'd10, 16'h0000);
    fetch("mrst11", 4'd11, 16'h0000);
    fetch("mrst0",  4'd0,  16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pio_instr_mem
`default_nettype wire
